dmem_responder: RTL and testbench

//  Memory-side responder for the core's data-access interface (request: we, addr, wdata, func3).

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_lane_align.sv | 71 +++++++
 rtl/dmem_responder.sv | 171 +++++++++++++++++
 tb/tb_dmem_responder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: funct3 encodings,
// responder FSM states and the funct3 legality check.
package dmem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'd0,
    F3_H  = 3'd1,
    F3_W  = 3'd2,
    F3_BU = 3'd4,
    F3_HU = 3'd5
  } dmem_f3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Stores only have byte/half/word forms; loads add the unsigned byte/half variants.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Valid/ready request and response channels between the core LSU and the
// data-memory responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_func3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_func3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_func3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: load extraction/extension, store byte
// enables and replicated store data, plus the misalignment flag.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [3:0]  be,
  output logic [31:0] store_data,
  output logic        misaligned
);

  logic [1:0]  eff_lo;
  logic [31:0] shifted;

  // Misaligned halves/words are snapped down to their natural boundary; the
  // top decides whether that is an error or silently accepted.
  always_comb begin
    misaligned = 1'b0;
    eff_lo     = addr_lo;
    case (func3)
      F3_H, F3_HU: begin
        misaligned = addr_lo[0];
        eff_lo     = {addr_lo[1], 1'b0};
      end
      F3_W: begin
        misaligned = (addr_lo != 2'b00);
        eff_lo     = 2'b00;
      end
      default: ;
    endcase
  end

  assign shifted = word >> {eff_lo, 3'b000};

  always_comb begin
    load_data = '0;
    case (func3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      F3_W:    load_data = word;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    be         = 4'b0000;
    store_data = wdata;
    case (func3)
      F3_B: begin
        be         = 4'b0001 << eff_lo;
        store_data = {4{wdata[7:0]}};
      end
      F3_H: begin
        be         = 4'b0011 << eff_lo;
        store_data = {2{wdata[15:0]}};
      end
      F3_W: begin
        be         = 4'b1111;
        store_data = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store at a time, fixed LATENCY.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [IDX_W+1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic             accept;
  logic             go_resp;
  logic             cur_we;
  logic [IDX_W+1:0] cur_addr;
  logic [31:0]      cur_wdata;
  logic [2:0]       cur_f3;
  logic [IDX_W-1:0] cur_idx;
  logic [31:0]      rd_word;
  logic [31:0]      ld_data;
  logic [31:0]      st_data;
  logic [3:0]       be;
  logic             misaligned;
  logic             access_err;
  logic             mem_we;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^bus.req_addr[31:IDX_W+2];

  assign accept = (state_q == IDLE) && bus.req_valid;

  // With LATENCY=0 the response is formed in the accept cycle, so the live
  // request is used directly instead of the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we    = bus.req_we;
      cur_addr  = bus.req_addr[IDX_W+1:0];
      cur_wdata = bus.req_wdata;
      cur_f3    = bus.req_func3;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_f3    = f3_q;
    end
  end

  assign cur_idx = cur_addr[IDX_W+1:2];
  assign rd_word = mem[cur_idx];

  dmem_lane_align u_align (
    .func3      (cur_f3),
    .addr_lo    (cur_addr[1:0]),
    .word       (rd_word),
    .wdata      (cur_wdata),
    .load_data  (ld_data),
    .be         (be),
    .store_data (st_data),
    .misaligned (misaligned)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  assign access_err = !f3_legal(cur_we, cur_f3) || misaligned;
`else
  assign access_err = !f3_legal(cur_we, cur_f3);
`endif

  assign go_resp = ((state_q == IDLE) && accept && (LATENCY == 0)) ||
                   ((state_q == WAIT) && (cnt_q == 4'd0));
  assign mem_we  = go_resp && cur_we && !access_err && !rst;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr[IDX_W+1:0];
          wdata_d = bus.req_wdata;
          f3_d    = bus.req_func3;
          cnt_d   = 4'(LATENCY);
          state_d = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (go_resp) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = (cur_we || access_err) ? 32'h0 : ld_data;
      rsp_err_d   = access_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage is deliberately not reset; writes land on the edge rsp_valid rises.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[cur_idx][8*b +: 8] <= st_data[8*b +: 8];
        end
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH_WORDS=1024, LATENCY=2);
// expectations follow DMEM_MISALIGN_TRAP_EN when it is defined.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS (1024),
    .LATENCY     (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One full transaction from an idle responder; waits are bounded.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] f3, output logic [31:0] rdata, output logic err,
                               output logic done);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_func3 = f3;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    done  = (bus.rsp_valid === 1'b1);
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic runAccess(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] f3,
                           input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    logic        dn;
    applyStimulus(we, addr, wdata, f3, rd, er, dn);
    checkOutput({tag, "_done"}, {31'b0, dn}, 32'd1);
    checkOutput({tag, "_data"}, rd, exp_data);
    checkOutput({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
  endtask

  initial begin
    int hits;
    rst           = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h0000_0010;
    bus.req_wdata = 32'hFFFF_FFFF;
    bus.req_func3 = F3_W;
    bus.rsp_ready = 1'b0;

    // Reset held for 3 cycles with a request pending: nothing captured.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
      checkOutput("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      checkOutput("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    end
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_req_ready", {31'b0, bus.req_ready}, 32'd1);
    checkOutput("idle_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);

    // Load extraction and extension.
    runAccess("sw_10",  1'b1, 32'h10, 32'hDEADBEEF, F3_W,  32'h0, 1'b0);
    runAccess("lb_13",  1'b0, 32'h13, 32'h0,        F3_B,  32'hFFFFFFDE, 1'b0);
    runAccess("lbu_13", 1'b0, 32'h13, 32'h0,        F3_BU, 32'h000000DE, 1'b0);
    runAccess("lh_12",  1'b0, 32'h12, 32'h0,        F3_H,  32'hFFFFDEAD, 1'b0);
    runAccess("lhu_10", 1'b0, 32'h10, 32'h0,        F3_HU, 32'h0000BEEF, 1'b0);

    // Partial stores leave other bytes alone.
    runAccess("sb_11",  1'b1, 32'h11, 32'h00000077, F3_B,  32'h0, 1'b0);
    runAccess("lw_sb",  1'b0, 32'h10, 32'h0,        F3_W,  32'hDEAD77EF, 1'b0);
    runAccess("sh_12",  1'b1, 32'h12, 32'h00001234, F3_H,  32'h0, 1'b0);
    runAccess("lw_sh",  1'b0, 32'h10, 32'h0,        F3_W,  32'h123477EF, 1'b0);

    // Latency and response hold with rsp_ready low.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h10;
    bus.req_func3 = F3_W;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    checkOutput("lat_busy", {31'b0, bus.req_ready}, 32'd0);
    checkOutput("lat_t0", {31'b0, bus.rsp_valid}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("lat_t%0d", k), {31'b0, bus.rsp_valid}, (k == 3) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
      checkOutput("hold_rdata", bus.rsp_rdata, 32'h123477EF);
      checkOutput("hold_busy", {31'b0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    checkOutput("done_valid", {31'b0, bus.rsp_valid}, 32'd0);
    checkOutput("done_ready", {31'b0, bus.req_ready}, 32'd1);

    // Illegal funct3 and misalignment.
    runAccess("sw_20",   1'b1, 32'h20, 32'h13572468, F3_W, 32'h0, 1'b0);
    runAccess("ill_st",  1'b1, 32'h20, 32'hFFFFFFFF, 3'd3, 32'h0, 1'b1);
    runAccess("lw_20",   1'b0, 32'h20, 32'h0,        F3_W, 32'h13572468, 1'b0);
    runAccess("ill_ld",  1'b0, 32'h20, 32'h0,        3'd6, 32'h0, 1'b1);
`ifdef DMEM_MISALIGN_TRAP_EN
    runAccess("lw_22",   1'b0, 32'h22, 32'h0,        F3_W, 32'h0, 1'b1);
    runAccess("lh_11",   1'b0, 32'h11, 32'h0,        F3_H, 32'h0, 1'b1);
`else
    runAccess("lw_22",   1'b0, 32'h22, 32'h0,        F3_W, 32'h13572468, 1'b0);
    runAccess("lh_11",   1'b0, 32'h11, 32'h0,        F3_H, 32'h000077EF, 1'b0);
`endif

    // Reset during WAIT abandons the pending store.
    runAccess("sw_40",   1'b1, 32'h40, 32'h11223344, F3_W, 32'h0, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h40;
    bus.req_wdata = 32'hA5A5A5A5;
    bus.req_func3 = F3_W;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_ready", {31'b0, bus.req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    hits = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) hits++;
    end
    checkOutput("abort_no_rsp", 32'(hits), 32'd0);
    runAccess("lw_40",   1'b0, 32'h40,   32'h0, F3_W, 32'h11223344, 1'b0);

    // Address wraps modulo depth.
    runAccess("lw_wrap", 1'b0, 32'h1040, 32'h0, F3_W, 32'h11223344, 1'b0);
    runAccess("sw_wrap", 1'b1, 32'h1040, 32'hCAFEF00D, F3_W, 32'h0, 1'b0);
    runAccess("lw_alias", 1'b0, 32'h40,  32'h0, F3_W, 32'hCAFEF00D, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
